float_argmax_stream: RTL and testbench



---
 rtl/float_argmax_stream.sv | 156 +++++++++++++++
 tb/tb_float_argmax_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float_argmax_stream.sv
// float_argmax_stream
//   Streams N IEEE-754 single-precision values (one per in_valid/in_ready
//   handshake), tracks the running maximum and the arrival index of its
//   first occurrence, and presents {out_max, out_idx} until consumed.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (aborts any run, no output)
//   start      one-cycle pulse, begins a run from IDLE
//   in_valid   in_data is valid
//   in_ready   element can be accepted this cycle (COLLECT only)
//   in_data    32-bit float element
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_max    maximum float of the run
//   out_idx    0-based arrival index of out_max
//   busy       high while collecting or holding a result
module float_argmax_stream #(
    parameter int N     = 10,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             accept;
    logic             last_beat;
    logic             first_beat;
    logic             cur_ge_in;
    logic             take_new;

    // Ordering on raw bits: sign first, then exponent, then mantissa, with
    // magnitude comparisons inverted for negative values. Identical patterns
    // compare as >=, so a tie never displaces the earlier element.
    function automatic logic float_ge(input logic [31:0] a, input logic [31:0] b);
        logic result;
        if (a == b) begin
            result = 1'b1;
        end else if (a[31] != b[31]) begin
            result = ~a[31];
        end else if (a[30:23] != b[30:23]) begin
            result = (a[30:23] > b[30:23]) ^ a[31];
        end else begin
            result = (a[22:0] > b[22:0]) ^ a[31];
        end
        return result;
    endfunction

    // Handshake / element bookkeeping
    always_comb begin
        accept     = (state == COLLECT) && in_valid;
        first_beat = (cnt == '0);
        last_beat  = accept && (cnt == IDX_W'(N - 1));
        cur_ge_in  = float_ge(out_max, in_data);
        take_new   = accept && (first_beat || !cur_ge_in);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here: a start coinciding
                // with out_ready is dropped, not queued.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath: element counter and running max/index. The result registers
    // double as the outputs, so they keep the previous result through IDLE
    // and are first overwritten by element 0 of the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            out_max <= '0;
            out_idx <= '0;
        end else begin
            if (state == IDLE && start) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= last_beat ? '0 : cnt + IDX_W'(1);
            end

            if (take_new) begin
                out_max <= in_data;
                out_idx <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_float_argmax_stream.sv
module tb_float_argmax_stream;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_max;
    logic [IDX_W-1:0] out_idx;
    logic             busy;

    float_argmax_stream #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Floats are mapped to an unsigned key whose natural order matches the
    // float ordering (positive: set the top bit; negative: invert all bits).
    function automatic logic [31:0] key(input logic [31:0] f);
        return f[31] ? ~f : (f | 32'h8000_0000);
    endfunction

    int          m_phase = 0;   // 0 idle, 1 collecting, 2 result held
    logic [31:0] m_q[$];
    logic [31:0] m_max = '0;
    int unsigned m_idx = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            m_max = '0;
            m_idx = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_q.delete();
                end
                1: if (in_valid) begin
                    m_q.push_back(in_data);
                    m_max = m_q[0];
                    m_idx = 0;
                    for (int i = 1; i < m_q.size(); i++) begin
                        if (key(m_q[i]) > key(m_max)) begin
                            m_max = m_q[i];
                            m_idx = i;
                        end
                    end
                    if (m_q.size() == N) m_phase = 2;
                end
                2: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("in_ready",  32'(in_ready),  32'(m_phase == 1));
        check("out_valid", 32'(out_valid), 32'(m_phase == 2));
        check("busy",      32'(busy),      32'(m_phase != 0));
        check("out_max",   out_max,        m_max);
        check("out_idx",   32'(out_idx),   32'(m_idx));
    end

    int acc = 0;
    always @(posedge clk) if (in_valid && in_ready) acc++;

    // ---------------- stimulus ----------------
    logic [31:0] vec [4];

    task automatic do_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // pat bit c = in_valid in cycle c; data advances only on valid cycles
    task automatic feed(input int unsigned len, input logic [15:0] pat);
        int unsigned k;
        k = 0;
        for (int unsigned c = 0; c < len; c++) begin
            in_valid = pat[c];
            in_data  = pat[c] ? vec[k] : 32'h7F7F_FFFF;
            @(posedge clk); #1;
            if (pat[c]) k++;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string name);
        int unsigned n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            total++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_dropped"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_max", out_max, 32'h0);
        check("rst_out_idx", 32'(out_idx), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // mixed signs, max in the middle
        vec = '{32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h4000_0000};
        acc = 0;
        do_start();
        feed(4, 16'h000F);
        check("t1_latency", 32'(out_valid), 32'h1);
        wait_done("t1");
        check("t1_max", out_max, 32'h4040_0000);
        check("t1_idx", 32'(out_idx), 32'h1);
        check("t1_model_max", m_max, 32'h4040_0000);
        check("t1_model_idx", 32'(m_idx), 32'h1);
        check("t1_accepts", 32'(acc), 32'h4);
        consume("t1");

        // all negative, tie keeps first
        vec = '{32'hC000_0000, 32'hBF80_0000, 32'hC040_0000, 32'hBF80_0000};
        do_start();
        feed(4, 16'h000F);
        wait_done("t2");
        check("t2_max", out_max, 32'hBF80_0000);
        check("t2_idx", 32'(out_idx), 32'h1);
        check("t2_model_idx", 32'(m_idx), 32'h1);
        consume("t2");

        // signed zeros: +0 beats -0
        vec = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        do_start();
        feed(4, 16'h000F);
        wait_done("t3");
        check("t3_max", out_max, 32'h0000_0000);
        check("t3_idx", 32'(out_idx), 32'h1);
        consume("t3");
        check("t3_idle_keeps_idx", 32'(out_idx), 32'h1);

        // backpressure on both sides
        vec = '{32'h4000_0000, 32'h3F80_0000, 32'h4080_0000, 32'h4040_0000};
        acc = 0;
        do_start();
        feed(7, 16'h0059);
        check("t4_accepts", 32'(acc), 32'h4);
        check("t4_valid", 32'(out_valid), 32'h1);
        repeat (5) begin
            @(posedge clk); #1;
            check("t4_hold_valid", 32'(out_valid), 32'h1);
            check("t4_hold_max", out_max, 32'h4080_0000);
            check("t4_hold_idx", 32'(out_idx), 32'h2);
        end
        consume("t4");

        // reset mid-run
        vec = '{32'h4100_0000, 32'h4120_0000, 32'h0, 32'h0};
        do_start();
        feed(2, 16'h0003);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_rst_in_ready", 32'(in_ready), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_out_valid", 32'(out_valid), 32'h0);
        check("t5_rst_out_max", out_max, 32'h0);
        check("t5_rst_out_idx", 32'(out_idx), 32'h0);
        vec = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h40B0_0000};
        do_start();
        feed(4, 16'h000F);
        wait_done("t5");
        check("t5_max", out_max, 32'h40B0_0000);
        check("t5_idx", 32'(out_idx), 32'h3);
        consume("t5");

        // in_valid in IDLE is ignored; start while busy is ignored
        in_valid = 1'b1;
        in_data  = 32'h7F00_0000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t6_idle_ignore_max", out_max, 32'h40B0_0000);
        vec = '{32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h4000_0000};
        acc = 0;
        do_start();
        start = 1'b1;
        feed(4, 16'h000F);
        start = 1'b0;
        check("t6_valid", 32'(out_valid), 32'h1);
        check("t6_max", out_max, 32'h4040_0000);
        check("t6_idx", 32'(out_idx), 32'h1);
        check("t6_accepts", 32'(acc), 32'h4);
        start = 1'b1;
        @(posedge clk); #1;
        check("t6_done_start_busy", 32'(busy), 32'h1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        check("t6_not_queued_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        check("t6_still_idle", 32'(busy), 32'h0);
        check("t6_idle_keeps_max", out_max, 32'h4040_0000);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
